// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser: Note On / Note Off decode with running status.
// Real-time bytes are transparent; all other messages are skipped in frame.
module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_rdy,
    input  logic [7:0] byte_data,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] note,
    output logic [6:0] velocity
);

    typedef enum logic [1:0] {
        IDLE,
        D1,
        D2
    } state_e;

    typedef enum logic [1:0] {
        NON,
        NOFF,
        SKIP1,
        SKIP2
    } msg_e;

    state_e     state_q, state_d;
    msg_e       msg_q, msg_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic       on_q, on_d;
    logic       off_q, off_d;

    logic       is_rt;
    logic       is_sys;
    logic       is_voice;
    logic       is_data;
    logic       ch_ok;
    msg_e       msg_sel;

    // Classify the incoming byte and its channel match.
    always_comb begin
        is_rt    = 1'b0;
        is_sys   = 1'b0;
        is_voice = 1'b0;
        is_data  = 1'b0;
        if (!byte_data[7]) begin
            is_data = 1'b1;
        end else if (byte_data[7:4] != 4'hF) begin
            is_voice = 1'b1;
        end else if (byte_data[3]) begin
            is_rt = 1'b1;
        end else begin
            is_sys = 1'b1;
        end
        ch_ok = OMNI || (byte_data[3:0] == CHANNEL);
    end

    // Message type selected by a channel-voice status byte.
    always_comb begin
        msg_sel = SKIP2;
        case (byte_data[7:4])
            4'h8:    msg_sel = ch_ok ? NOFF : SKIP2;
            4'h9:    msg_sel = ch_ok ? NON : SKIP2;
            4'hC:    msg_sel = SKIP1;
            4'hD:    msg_sel = SKIP1;
            default: msg_sel = SKIP2;
        endcase
    end

    // Next-state, data latch and event generation.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        d1_d    = d1_q;
        note_d  = note_q;
        vel_d   = vel_q;
        on_d    = 1'b0;
        off_d   = 1'b0;
        if (byte_rdy) begin
            if (is_rt) begin
                // transparent: nothing changes
                state_d = state_q;
            end else if (is_sys) begin
                state_d = IDLE;
            end else if (is_voice) begin
                msg_d   = msg_sel;
                state_d = D1;
            end else if (is_data) begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    D1: begin
                        d1_d    = byte_data[6:0];
                        state_d = (msg_q == SKIP1) ? D1 : D2;
                    end
                    D2: begin
                        state_d = D1;
                        if (msg_q == NON || msg_q == NOFF) begin
                            note_d = d1_q;
                            vel_d  = byte_data[6:0];
                        end
                        if (msg_q == NON) begin
                            on_d  = (byte_data[6:0] != 7'd0);
                            off_d = (byte_data[6:0] == 7'd0);
                        end
                        if (msg_q == NOFF) begin
                            off_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= SKIP2;
            d1_q    <= 7'd0;
            note_q  <= 7'd0;
            vel_q   <= 7'd0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            d1_q    <= d1_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            on_q    <= on_d;
            off_q   <= off_d;
        end
    end

    assign note_on  = on_q;
    assign note_off = off_q;
    assign note     = note_q;
    assign velocity = vel_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed cases plus random byte streams
// checked against a message-level model (two channel configurations).
module tb_midi_note_decoder;

    logic       clk;
    logic       rst_n;
    logic       byte_rdy;
    logic [7:0] byte_data;

    logic       on0, off0, on1, off1;
    logic [6:0] note0, vel0, note1, vel1;

    int n_chk;
    int n_err;

    // model state, index 0 = CHANNEL 0, index 1 = CHANNEL 3 OMNI
    logic [3:0] m_ch   [2];
    bit         m_omni [2];
    bit         rs_v   [2];
    logic [7:0] rs     [2];
    int         cnt    [2];
    logic [6:0] first  [2];
    logic       e_on   [2];
    logic       e_off  [2];
    logic [6:0] e_note [2];
    logic [6:0] e_vel  [2];

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .byte_rdy(byte_rdy), .byte_data(byte_data),
        .note_on(on0), .note_off(off0), .note(note0), .velocity(vel0)
    );

    midi_note_decoder #(.CHANNEL(4'd3), .OMNI(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .byte_rdy(byte_rdy), .byte_data(byte_data),
        .note_on(on1), .note_off(off1), .note(note1), .velocity(vel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rs_v[k]   = 0;
            rs[k]     = 8'h00;
            cnt[k]    = 0;
            first[k]  = 7'd0;
            e_on[k]   = 1'b0;
            e_off[k]  = 1'b0;
            e_note[k] = 7'd0;
            e_vel[k]  = 7'd0;
        end
    endtask

    // message-level reference: running status plus collected data bytes
    task automatic model_step(input logic rdy, input logic [7:0] b);
        int need;
        bit chm;
        for (int k = 0; k < 2; k++) begin
            e_on[k]  = 1'b0;
            e_off[k] = 1'b0;
            if (!rdy) continue;
            if (b >= 8'hF8) begin
                // real-time: no effect
            end else if (b >= 8'hF0) begin
                rs_v[k] = 0;
                cnt[k]  = 0;
            end else if (b >= 8'h80) begin
                rs_v[k] = 1;
                rs[k]   = b;
                cnt[k]  = 0;
            end else if (rs_v[k]) begin
                need = (rs[k][7:4] == 4'hC || rs[k][7:4] == 4'hD) ? 1 : 2;
                chm  = m_omni[k] || (rs[k][3:0] == m_ch[k]);
                if (need == 2 && cnt[k] == 0) begin
                    first[k] = b[6:0];
                    cnt[k]   = 1;
                end else begin
                    cnt[k] = 0;
                    if (need == 2 && chm && rs[k][7:4] == 4'h9) begin
                        e_note[k] = first[k];
                        e_vel[k]  = b[6:0];
                        if (b[6:0] != 0) e_on[k] = 1'b1;
                        else e_off[k] = 1'b1;
                    end else if (need == 2 && chm && rs[k][7:4] == 4'h8) begin
                        e_note[k] = first[k];
                        e_vel[k]  = b[6:0];
                        e_off[k]  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".on0"},   on0,   e_on[0]);
        check_eq({tag, ".off0"},  off0,  e_off[0]);
        check_eq({tag, ".note0"}, note0, e_note[0]);
        check_eq({tag, ".vel0"},  vel0,  e_vel[0]);
        check_eq({tag, ".on1"},   on1,   e_on[1]);
        check_eq({tag, ".off1"},  off1,  e_off[1]);
        check_eq({tag, ".note1"}, note1, e_note[1]);
        check_eq({tag, ".vel1"},  vel1,  e_vel[1]);
    endtask

    task automatic step(input string tag, input logic rdy, input logic [7:0] b);
        @(negedge clk);
        byte_rdy  = rdy;
        byte_data = b;
        model_step(rdy, b);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom));
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [3:0] ch;
        r  = $urandom_range(0, 99);
        ch = (r % 3 == 0) ? 4'd0 : ((r % 3 == 1) ? 4'd3 : 4'($urandom));
        if (r < 55) return {1'b0, 7'($urandom)};
        if (r < 70) return {($urandom_range(0, 1) != 0) ? 4'h9 : 4'h8, ch};
        if (r < 78) return {($urandom_range(0, 1) != 0) ? 4'hC : 4'hD, ch};
        if (r < 84) return {4'hA + 4'($urandom_range(0, 1)) * 4'h1, ch};
        if (r < 90) return 8'hF0 + 8'($urandom_range(0, 7));
        return 8'hF8 + 8'($urandom_range(0, 7));
    endfunction

    initial begin
        n_chk     = 0;
        n_err     = 0;
        m_ch[0]   = 4'd0;
        m_omni[0] = 0;
        m_ch[1]   = 4'd3;
        m_omni[1] = 1;
        model_reset();
        rst_n     = 1'b0;
        byte_rdy  = 1'b0;
        byte_data = 8'h00;
        #23;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset", 2);

        // basic note on
        send("t1", 8'h90);
        send("t1", 8'h3C);
        send("t1", 8'h64);
        check_eq("t1.on_const", on0, 1'b1);
        check_eq("t1.note_const", note0, 7'h3C);
        check_eq("t1.vel_const", vel0, 7'h64);
        check_eq("t1.off_const", off0, 1'b0);
        idle("t1.hold", 2);

        // running status, velocity 0 as note off
        send("t2", 8'h90);
        send("t2", 8'h3C);
        send("t2", 8'h64);
        send("t2", 8'h40);
        send("t2", 8'h00);
        check_eq("t2.off_const", off0, 1'b1);
        check_eq("t2.note_const", note0, 7'h40);
        idle("t2.hold", 1);

        // note off, channel mismatch
        send("t3", 8'h80);
        send("t3", 8'h3C);
        send("t3", 8'h7F);
        send("t3", 8'h91);
        send("t3", 8'h3C);
        send("t3", 8'h64);
        check_eq("t3.mismatch_on0", on0, 1'b0);
        check_eq("t3.omni_on1", on1, 1'b1);

        // real-time transparent, system common aborts
        send("t4", 8'h90);
        send("t4", 8'h3C);
        send("t4", 8'hF8);
        send("t4", 8'h64);
        send("t4", 8'h90);
        send("t4", 8'h3C);
        send("t4", 8'hF0);
        send("t4", 8'h64);

        // program change skipped, control change no pulse
        send("t5", 8'hC0);
        send("t5", 8'h05);
        send("t5", 8'h90);
        send("t5", 8'h30);
        send("t5", 8'h50);
        send("t5", 8'hB0);
        send("t5", 8'h07);
        send("t5", 8'h64);

        // status in D2 aborts pending message
        send("t5b", 8'h90);
        send("t5b", 8'h22);
        send("t5b", 8'h80);
        send("t5b", 8'h11);
        send("t5b", 8'h05);

        // async reset mid-message, then a lone data byte
        send("t6", 8'h90);
        send("t6", 8'h3C);
        send("t6", 8'h64);
        @(negedge clk);
        byte_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        @(negedge clk);
        rst_n = 1'b1;
        send("t6", 8'h64);
        send("t6", 8'h3C);
        send("t6", 8'h64);

        // random streams with gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 80) send("rnd", rand_byte());
            else step("rnd_gap", 1'b0, rand_byte());
        end
        idle("tail", 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
